// File: rtl/of_unit.sv
// rtl/of_unit.sv - SimpleRisc operand-fetch stage: register file, decoder and OF/EX latch.
module of_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instruction_in,
   input  logic [31:0] pc_in,
   input  logic [3:0]  wr_adr,
   input  logic [31:0] wr_data,
   input  logic        is_wb,
   output logic [31:0] pc_out,
   output logic [31:0] instruction_out,
   output logic [23:0] control_bus_out,
   output logic [31:0] btarget,
   output logic [31:0] A,
   output logic [31:0] B,
   output logic [31:0] op2_out
);

   localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_MUL = 5'd2,  OP_DIV = 5'd3;
   localparam logic [4:0] OP_MOD = 5'd4,  OP_CMP = 5'd5,  OP_AND = 5'd6,  OP_OR  = 5'd7;
   localparam logic [4:0] OP_NOT = 5'd8,  OP_MOV = 5'd9,  OP_LSL = 5'd10, OP_LSR = 5'd11;
   localparam logic [4:0] OP_ASR = 5'd12, OP_LD  = 5'd14, OP_ST  = 5'd15;
   localparam logic [4:0] OP_BEQ = 5'd16, OP_BGT = 5'd17, OP_B   = 5'd18, OP_CALL = 5'd19;
   localparam logic [4:0] OP_RET = 5'd20;

   logic [31:0] rf [16];

   logic [4:0]  opcode;
   logic        ibit;
   logic [3:0]  rd, rs1, rs2;
   logic [1:0]  modifier;
   logic [15:0] imm16;
   logic [26:0] off27;

   assign opcode   = instruction_in[31:27];
   assign ibit     = instruction_in[26];
   assign rd       = instruction_in[25:22];
   assign rs1      = instruction_in[21:18];
   assign rs2      = instruction_in[17:14];
   assign modifier = instruction_in[17:16];
   assign imm16    = instruction_in[15:0];
   assign off27    = instruction_in[26:0];

   logic [3:0]  a_adr, b_adr;
   logic [31:0] a_val, b_val, imm_ext, op2_val, bt_val;
   logic [23:0] ctrl;

   assign a_adr = (opcode == OP_RET) ? 4'd15 : rs1;
   assign b_adr = (opcode == OP_ST)  ? rd    : rs2;

   // Write-through: a register written this cycle is seen by the instruction decoded now.
   assign a_val = (is_wb && wr_adr == a_adr) ? wr_data : rf[a_adr];
   assign b_val = (is_wb && wr_adr == b_adr) ? wr_data : rf[b_adr];

   always_comb begin
      imm_ext = {{16{imm16[15]}}, imm16};
      case (modifier)
         2'b01:   imm_ext = {16'h0, imm16};
         2'b10:   imm_ext = {imm16, 16'h0};
         default: imm_ext = {{16{imm16[15]}}, imm16};
      endcase
   end

   assign op2_val = ibit ? imm_ext : b_val;
   assign bt_val  = pc_in + {{3{off27[26]}}, off27, 2'b00};

   always_comb begin
      ctrl = '0;
      case (opcode)
         OP_ADD:  ctrl[9]  = 1'b1;
         OP_SUB:  ctrl[10] = 1'b1;
         OP_CMP:  ctrl[11] = 1'b1;
         OP_MUL:  ctrl[12] = 1'b1;
         OP_DIV:  ctrl[13] = 1'b1;
         OP_MOD:  ctrl[14] = 1'b1;
         OP_LSL:  ctrl[15] = 1'b1;
         OP_LSR:  ctrl[16] = 1'b1;
         OP_ASR:  ctrl[17] = 1'b1;
         OP_OR:   ctrl[18] = 1'b1;
         OP_AND:  ctrl[19] = 1'b1;
         OP_NOT:  ctrl[20] = 1'b1;
         OP_MOV:  ctrl[21] = 1'b1;
         OP_LD:   begin ctrl[1] = 1'b1; ctrl[9] = 1'b1; end
         OP_ST:   begin ctrl[0] = 1'b1; ctrl[9] = 1'b1; end
         OP_BEQ:  ctrl[2] = 1'b1;
         OP_BGT:  ctrl[3] = 1'b1;
         OP_B:    ctrl[7] = 1'b1;
         OP_CALL: begin ctrl[8] = 1'b1; ctrl[7] = 1'b1; ctrl[6] = 1'b1; end
         OP_RET:  begin ctrl[4] = 1'b1; ctrl[7] = 1'b1; end
         default: ctrl[22] = 1'b1;
      endcase
      // ALU ops occupy opcodes 0..12; nop (13) and branches never take an immediate.
      if (opcode <= OP_ASR || opcode == OP_LD || opcode == OP_ST)
         ctrl[5] = ibit;
      if ((opcode <= OP_ASR && opcode != OP_CMP) || opcode == OP_LD)
         ctrl[6] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 16; i++)
            rf[i] <= '0;
         pc_out          <= '0;
         instruction_out <= '0;
         control_bus_out <= '0;
         btarget         <= '0;
         A               <= '0;
         B               <= '0;
         op2_out         <= '0;
      end else begin
         if (is_wb)
            rf[wr_adr] <= wr_data;
         pc_out          <= pc_in;
         instruction_out <= instruction_in;
         control_bus_out <= ctrl;
         btarget         <= bt_val;
         A               <= a_val;
         B               <= b_val;
         op2_out         <= op2_val;
      end
   end

endmodule

// File: tb/tb_of_unit.sv
// tb/tb_of_unit.sv - scoreboard bench for of_unit against a behavioural model.
module tb_of_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instruction_in, pc_in, wr_data;
   logic [3:0]  wr_adr;
   logic        is_wb;
   logic [31:0] pc_out, instruction_out, btarget, A, B, op2_out;
   logic [23:0] control_bus_out;

   of_unit dut (
      .clk(clk), .reset(reset), .instruction_in(instruction_in), .pc_in(pc_in),
      .wr_adr(wr_adr), .wr_data(wr_data), .is_wb(is_wb), .pc_out(pc_out),
      .instruction_out(instruction_out), .control_bus_out(control_bus_out),
      .btarget(btarget), .A(A), .B(B), .op2_out(op2_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc, instr, bt, a, b, op2;
      logic [23:0] ctrl;
   } exp_t;

   exp_t        sbq[$];
   logic [31:0] mrf [16];
   int          total = 0;
   int          passed = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [31:0] mk_reg(int op, int i, int rd, int rs1, int rs2);
      logic [31:0] w;
      w = 32'((op << 27) | (i << 26) | (rd << 22) | (rs1 << 18) | (rs2 << 14));
      return w;
   endfunction

   function automatic logic [31:0] mk_imm(int op, int i, int rd, int rs1, int md, int imm);
      logic [31:0] w;
      w = 32'((op << 27) | (i << 26) | (rd << 22) | (rs1 << 18) | (md << 16) | (imm & 32'hFFFF));
      return w;
   endfunction

   function automatic logic [23:0] model_ctrl(int op, logic ib);
      int alu_tab[21] = '{9, 10, 12, 13, 14, 11, 19, 18, 20, 21, 15, 16, 17, 22, 9, 9, -1, -1, -1, -1, -1};
      int alu_bit;
      logic [23:0] c;
      c = '0;
      alu_bit = (op >= 21) ? 22 : alu_tab[op];
      if (alu_bit >= 0) c[alu_bit] = 1'b1;
      c[0] = (op == 15);
      c[1] = (op == 14);
      c[2] = (op == 16);
      c[3] = (op == 17);
      c[4] = (op == 20);
      c[5] = ((op <= 12) || op == 14 || op == 15) ? ib : 1'b0;
      c[6] = ((op <= 12 && op != 5) || op == 14 || op == 19);
      c[7] = (op == 18 || op == 19 || op == 20);
      c[8] = (op == 19);
      return c;
   endfunction

   // One clock of stimulus: drive at the falling edge, predict the latched result, then commit writes.
   task automatic cycle(input logic [31:0] ins, input logic [31:0] pc, input logic wb,
                        input logic [3:0] wa, input logic [31:0] wd, input logic rst_n);
      exp_t e;
      int op, ra, rb, imm, off;
      @(negedge clk);
      instruction_in = ins; pc_in = pc; is_wb = wb; wr_adr = wa; wr_data = wd; reset = rst_n;
      if (!rst_n) begin
         e = '{pc: 0, instr: 0, bt: 0, a: 0, b: 0, op2: 0, ctrl: 0};
         for (int k = 0; k < 16; k++) mrf[k] = '0;
      end else begin
         op = int'(ins[31:27]);
         ra = (op == 20) ? 15 : int'(ins[21:18]);
         rb = (op == 15) ? int'(ins[25:22]) : int'(ins[17:14]);
         e.a = (wb && int'(wa) == ra) ? wd : mrf[ra];
         e.b = (wb && int'(wa) == rb) ? wd : mrf[rb];
         case (ins[17:16])
            2'b01:   imm = int'(ins[15:0]);
            2'b10:   imm = int'(ins[15:0]) * 65536;
            default: imm = int'($signed(ins[15:0]));
         endcase
         e.op2 = ins[26] ? 32'(imm) : e.b;
         off = int'(ins[26:0]);
         if (off >= (1 << 26)) off = off - (1 << 27);
         e.bt = 32'(pc + 32'(off * 4));
         e.pc = pc;
         e.instr = ins;
         e.ctrl = model_ctrl(op, ins[26]);
         if (wb) mrf[wa] = wd;
      end
      sbq.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("pc_out", pc_out, e.pc);
            chk("instruction_out", instruction_out, e.instr);
            chk("control_bus_out", {8'h0, control_bus_out}, {8'h0, e.ctrl});
            chk("btarget", btarget, e.bt);
            chk("A", A, e.a);
            chk("B", B, e.b);
            chk("op2_out", op2_out, e.op2);
         end
      end
   end

   localparam logic [31:0] NOP = 32'h6800_0000;

   initial begin
      reset = 1'b0; instruction_in = '0; pc_in = '0; wr_adr = '0; wr_data = '0; is_wb = 1'b0;
      // Reset with a live instruction, then prove r5 is cleared by reset.
      cycle(32'hDEAD_BEEF, 32'h44, 1'b1, 4'd5, 32'h5555_5555, 1'b0);
      cycle(NOP, 0, 1'b1, 4'd5, 32'h5555_5555, 1'b1);
      cycle(NOP, 0, 1'b1, 4'd5, 32'h1234_5678, 1'b0);
      cycle(mk_reg(0, 0, 0, 5, 5), 0, 1'b0, 4'd0, 0, 1'b1);
      // Register writes and a register-register add.
      cycle(NOP, 0, 1'b1, 4'd1, 32'hAAAA_AAAA, 1'b1);
      cycle(NOP, 0, 1'b1, 4'd2, 32'hBBBB_BBBB, 1'b1);
      cycle(mk_reg(0, 0, 3, 1, 2), 32'h10, 1'b0, 4'd0, 0, 1'b1);
      // Immediate extension modes.
      for (int md = 0; md < 4; md++)
         cycle(mk_imm(1, 1, 4, 1, md, 16'hFFFF), 32'h20, 1'b0, 4'd0, 0, 1'b1);
      // Store, branches with negative and wrapping offsets, ret with bypass on r15.
      cycle(mk_imm(15, 1, 2, 1, 0, 4), 32'h24, 1'b0, 4'd0, 0, 1'b1);
      cycle({5'b10000, 27'h7FF_FFFE}, 32'h100, 1'b0, 4'd0, 0, 1'b1);
      cycle({5'b10010, 27'h7FF_FFFF}, 32'h0, 1'b0, 4'd0, 0, 1'b1);
      cycle({5'b10100, 27'h0}, 32'h30, 1'b1, 4'd15, 32'd1234, 1'b1);
      cycle({5'b10011, 27'h10}, 32'h40, 1'b0, 4'd0, 0, 1'b1);
      // Every opcode, including the 21..31 range that decodes as nop.
      for (int op = 0; op < 32; op++)
         cycle(mk_reg(op, op & 1, op & 15, (op + 1) & 15, (op + 2) & 15), 32'(op * 4), 1'b0, 4'd0, 0, 1'b1);
      // Randomized traffic with occasional mid-stream reset.
      for (int n = 0; n < 400; n++)
         cycle($urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
               ($urandom_range(0, 39) != 0));
      for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
      #2;
      total++;
      if (sbq.size() == 0) passed++;
      else $display("FAIL drain: got %0d pending expected 0", sbq.size());
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
